// File: rtl/jtcop_pkg.sv
// Shared encodings and the default Sly Spy routing table for the tilemap
// window scrambler.
package jtcop_pkg;
    localparam int EW = 5;

    localparam logic [1:0] FN_MODE = 2'd0;
    localparam logic [1:0] FN_SFT  = 2'd1;
    localparam logic [1:0] FN_MAP  = 2'd2;
    localparam logic [1:0] FN_NONE = 2'd3;

    typedef struct packed {
        logic       en;
        logic [1:0] fn;
        logic [1:0] ch;
    } map_entry_t;

    function automatic logic [EW-1:0] ent(input logic [1:0] fn, input logic [1:0] ch);
        return {1'b1, fn, ch};
    endfunction

    // Index = {mapsel[1:0], win[2:0]}; unlisted windows stay disabled.
    function automatic logic [32*EW-1:0] slyspy_tbl();
        logic [32*EW-1:0] t;
        t = '0;
        t[ 0*EW +: EW] = ent(FN_MODE, 2'd1);
        t[ 1*EW +: EW] = ent(FN_MODE, 2'd0);
        t[ 2*EW +: EW] = ent(FN_SFT,  2'd0);
        t[ 3*EW +: EW] = ent(FN_MAP,  2'd0);
        t[ 4*EW +: EW] = ent(FN_SFT,  2'd1);
        t[ 5*EW +: EW] = ent(FN_MAP,  2'd1);
        t[ 8*EW +: EW] = ent(FN_SFT,  2'd1);
        t[ 9*EW +: EW] = ent(FN_MAP,  2'd1);
        t[10*EW +: EW] = ent(FN_MODE, 2'd1);
        t[11*EW +: EW] = ent(FN_MODE, 2'd0);
        t[12*EW +: EW] = ent(FN_MAP,  2'd0);
        t[13*EW +: EW] = ent(FN_SFT,  2'd0);
        t[16*EW +: EW] = ent(FN_MAP,  2'd1);
        t[17*EW +: EW] = ent(FN_SFT,  2'd1);
        t[18*EW +: EW] = ent(FN_MAP,  2'd0);
        t[19*EW +: EW] = ent(FN_SFT,  2'd0);
        t[20*EW +: EW] = ent(FN_MODE, 2'd1);
        t[21*EW +: EW] = ent(FN_MODE, 2'd0);
        t[24*EW +: EW] = ent(FN_MODE, 2'd0);
        t[25*EW +: EW] = ent(FN_MODE, 2'd1);
        t[26*EW +: EW] = ent(FN_SFT,  2'd1);
        t[27*EW +: EW] = ent(FN_MAP,  2'd1);
        t[28*EW +: EW] = ent(FN_SFT,  2'd0);
        t[29*EW +: EW] = ent(FN_MAP,  2'd0);
        // Enabled but unroutable: a dead function code and a chip beyond NCH=2.
        t[30*EW +: EW] = ent(FN_NONE, 2'd0);
        t[31*EW +: EW] = ent(FN_MODE, 2'd2);
        return t;
    endfunction

    localparam logic [32*EW-1:0] SLYSPY_TBL = slyspy_tbl();
endpackage

// File: rtl/jtcop_mapsel_if.sv
// CPU-side bus and chip-select bundle for jtcop_mapsel.
interface jtcop_mapsel_if #(
    parameter int RW   = 3,
    parameter int CNTW = 2,
    parameter int NCH  = 2
);
    logic            ASn;
    logic            RnW;
    logic            reg_hit;
    logic [RW-1:0]   win;
    logic            dbg_en;
    logic [CNTW-1:0] dbg_sel;
    logic [NCH-1:0]  mode_cs;
    logic [NCH-1:0]  sft_cs;
    logic [NCH-1:0]  map_cs;
    logic            disp_cs;
    logic            up_cs;
    logic            clr_cs;
    logic [CNTW-1:0] mapsel;

    modport master (
        output ASn, RnW, reg_hit, win, dbg_en, dbg_sel,
        input  mode_cs, sft_cs, map_cs, disp_cs, up_cs, clr_cs, mapsel
    );

    modport slave (
        input  ASn, RnW, reg_hit, win, dbg_en, dbg_sel,
        output mode_cs, sft_cs, map_cs, disp_cs, up_cs, clr_cs, mapsel
    );
endinterface

// File: rtl/jtcop_edgecnt.sv
// Edge-triggered step/clear counter; the result is only latched into the
// routing between bus cycles so a decode never changes mid-access.
module jtcop_edgecnt #(
    parameter int CNTW = 2,
    parameter int SAT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ASn,
    input  logic            up,
    input  logic            clr,
    output logic [CNTW-1:0] msel
);
    logic            up_l, clr_l;
    logic [CNTW-1:0] premap;
    logic            up_edge, clr_edge;

    assign up_edge  = up  & ~up_l;
    assign clr_edge = clr & ~clr_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_l   <= 1'b0;
            clr_l  <= 1'b0;
            premap <= '0;
            msel   <= '0;
        end else begin
            up_l  <= up;
            clr_l <= clr;
            if (clr_edge)
                premap <= '0;
            else if (up_edge && !(SAT != 0 && premap == '1))
                premap <= premap + 1'b1;
            if (ASn)
                msel <= premap;
        end
    end
endmodule

// File: rtl/jtcop_mapsel.sv
// Table-driven tilemap window scrambler: strobe decode, routing selection
// and per-chip select fan-out.
module jtcop_mapsel
    import jtcop_pkg::*;
#(
    parameter int RW     = 3,
    parameter int CNTW   = 2,
    parameter int NCH    = 2,
    parameter int UPWIN  = 2,
    parameter int CLRWIN = 5,
    parameter int SAT    = 0,
    parameter logic [(2**(CNTW+RW))*EW-1:0] MAPTBL = SLYSPY_TBL
) (
    input logic          clk,
    input logic          rst,
    jtcop_mapsel_if.slave bus
);
    logic                 cyc;
    logic [CNTW-1:0]      msel;
    logic [CNTW+RW-1:0]   idx;
    map_entry_t           e;

    // Everything combinational is held quiet while reset is asserted.
    assign cyc         = ~bus.ASn & bus.reg_hit & ~rst;
    assign bus.up_cs   = cyc &  bus.RnW & (bus.win == RW'(UPWIN));
    assign bus.clr_cs  = cyc & ~bus.RnW & (bus.win == RW'(CLRWIN));

    jtcop_edgecnt #(
        .CNTW (CNTW),
        .SAT  (SAT)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ASn  (bus.ASn),
        .up   (bus.up_cs),
        .clr  (bus.clr_cs),
        .msel (msel)
    );

    assign bus.mapsel = bus.dbg_en ? bus.dbg_sel : (rst ? '0 : msel);

    assign idx = {bus.mapsel, bus.win};
    assign e   = map_entry_t'(MAPTBL[int'(idx)*EW +: EW]);

    // Chip indices at or above NCH simply never match a lane.
    always_comb begin
        bus.mode_cs = '0;
        bus.sft_cs  = '0;
        bus.map_cs  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cyc && e.en && e.ch == 2'(i)) begin
                case (e.fn)
                    FN_MODE: bus.mode_cs[i] = 1'b1;
                    FN_SFT:  bus.sft_cs[i]  = 1'b1;
                    FN_MAP:  bus.map_cs[i]  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.disp_cs = (|bus.sft_cs) | (|bus.map_cs);
endmodule

// File: doc/jtcop_mapsel.md
# jtcop_mapsel

Parametrised tilemap-window scrambler for DECO-style protection schemes. The CPU reads a trigger window to step a hidden counter and writes a clear window to reset it. The latched counter value selects one of 2^CNTW routings, each mapping 2^RW address windows onto mode/scroll/map chip selects of up to four BAC06 chips. It sits beside the main address decoder, which supplies the qualified region hit. It generalises fixed 2-bit, 2-chip hardwired scrambling to a table-driven, configurable-width block with wrap/saturate modes and a debug override.

## Interface
Parameters:
- RW, 3: window-select bits; 2^RW windows per region.
- CNTW, 2: counter/mapsel width; 2^CNTW routings.
- NCH, 2: number of tilemap chips, 1..4.
- UPWIN, 2: window index whose read steps the counter.
- CLRWIN, 5: window index whose write clears the counter.
- SAT, 0: 0 = counter wraps; 1 = counter saturates at all-ones.
- MAPTBL, Sly Spy scramble: packed table of 2^CNTW × 2^RW entries, 5 bits each: {en, fn[1:0], ch[1:0]}. fn: 0 = mode, 1 = sft, 2 = map. Entry index = {mapsel, win}.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- ASn, in, 1: CPU address strobe, active low.
- RnW, in, 1: CPU read/not-write.
- reg_hit, in, 1: region match from the main decoder.
- win, in, RW: address window bits.
- dbg_en, in, 1: forces the routing to dbg_sel.
- dbg_sel, in, CNTW: forced routing.
- mode_cs, out, NCH: per-chip mode-register select.
- sft_cs, out, NCH: per-chip scroll-RAM select.
- map_cs, out, NCH: per-chip tilemap-RAM select.
- disp_cs, out, 1: OR of all sft_cs and map_cs.
- up_cs, out, 1: trigger-window read strobe (combinational).
- clr_cs, out, 1: clear-window write strobe (combinational).
- mapsel, out, CNTW: active routing.

## Operation
- up_cs = !ASn & reg_hit & win==UPWIN & RnW.
- clr_cs = !ASn & reg_hit & win==CLRWIN & !RnW.
- Registers: up_l, clr_l (previous strobe values), premap (CNTW bits), msel (CNTW bits).
- Rising edge of clr_cs: premap <= 0.
- Rising edge of up_cs: premap <= premap+1.
  - SAT=0: wraps from all-ones to 0.
  - SAT=1: holds at all-ones.
- If both edges fall on the same cycle, clear wins.
- A strobe held asserted over many cycles counts once; it counts again only after deasserting.
- msel <= premap only in cycles where ASn=1. The routing never changes inside a bus cycle.
- mapsel = dbg_en ? dbg_sel : msel. dbg_en does not disturb premap or msel.
- Entry e = MAPTBL[{mapsel,win}]. When !ASn & reg_hit & e.en & e.ch<NCH, exactly one bit is set: bit e.ch of the vector chosen by e.fn.
- fn=3 or ch≥NCH: no select is asserted.
- The trigger and clear windows may also be mapped in MAPTBL; the strobes and the selects are independent.

## Timing
- Reset (sync): premap=0, msel=0, up_l=0, clr_l=0. While rst is high all outputs are 0, except mapsel, which follows dbg_en ? dbg_sel : 0.
- Chip selects, up_cs and clr_cs: combinational, zero latency from ASn, win and reg_hit.
- premap updates at the clock edge that samples the first cycle of a strobe.
- msel follows premap at the first clock edge with ASn=1 after that. A new routing applies from the next bus cycle onward.
- Asserting rst mid-bus-cycle returns the routing to 0 at the next edge, regardless of ASn.

## Structure
- Shared package jtcop_pkg holds:
  - the fn encodings (FN_MODE, FN_SFT, FN_MAP);
  - the entry-width constant (5);
  - the Sly Spy default table constant.
- One sub-module, jtcop_edgecnt: the edge-detected up/clear counter with SAT, CNTW and clear-priority handling, plus the ASn-gated latch.
- Table lookup and select fan-out stay in the top module.

## Test plan
- Reset, then a read at win=0 → mode_cs=2'b10 (chip 1), mapsel=0.
- Two reads at win=2 with ASn toggling between them → premap=2. At the next ASn-high edge mapsel=2; a read at win=0 then gives map_cs=2'b10.
- Five up reads with CNTW=2: SAT=0 → mapsel=1; SAT=1 → mapsel=3.
- Up read, then a write at win=5 → mapsel=0. A forced same-cycle edge of both strobes → premap=0.
- Strobe held 10 cycles → premap increments once. While ASn stays low after the increment, mapsel is unchanged.
- dbg_en=1, dbg_sel=3 → mapsel=3 immediately. On release, mapsel returns to msel. rst pulsed mid-cycle → mapsel=0 next edge.
